// File: rtl/history_combiner.sv
// Per-lane DEPTH-deep history with AND/OR reduction selected by a hysteretic mode FSM.
// Optional build macro HISTORY_FILL_GATE_EN forces y to 0 until the history is fully populated.
//
// state | meaning
// S_AND | y is the AND of the current sample and its history
// S_OR  | y is the OR of the current sample and its history
module history_combiner #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int HYST  = 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic             b,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic             mode,
    output logic             i_am_in_S0,
    output logic             i_am_in_S1
);

    localparam int HCW = $clog2(HYST + 1);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam logic [HCW-1:0] HYST_C = HCW'(HYST);
    localparam logic [FCW-1:0] DEPTH_C = FCW'(DEPTH);

    typedef enum logic {
        S_AND = 1'b0,
        S_OR  = 1'b1
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [HCW-1:0]              hyst_cnt;
    logic [HCW-1:0]              hyst_next;
    logic [DEPTH-1:0][WIDTH-1:0] hist;
    logic [FCW-1:0]              fill_cnt;
    logic [WIDTH-1:0]            red_and;
    logic [WIDTH-1:0]            red_or;
    logic [WIDTH-1:0]            y_next;
    logic                        fill_full;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= S_AND;
            hyst_cnt <= '0;
        end else begin
            state    <= state_next;
            hyst_cnt <= hyst_next;
        end
    end

    always_comb begin
        state_next = state;
        hyst_next  = hyst_cnt;
        case (state)
            S_AND, S_OR: begin
                if (b == state) begin
                    hyst_next = '0;
                end else if (hyst_cnt + HCW'(1) == HYST_C) begin
                    state_next = (state == S_AND) ? S_OR : S_AND;
                    hyst_next  = '0;
                end else begin
                    hyst_next = hyst_cnt + HCW'(1);
                end
            end
            default: begin
                state_next = S_AND;
                hyst_next  = '0;
            end
        endcase
    end

    always_comb begin
        mode       = (state == S_OR);
        i_am_in_S0 = (state == S_AND);
        i_am_in_S1 = (state == S_OR);
    end

    // Reduction uses the pre-shift history and the mode before this edge's transition.
    always_comb begin
        red_and = a;
        red_or  = a;
        for (int k = 0; k < DEPTH; k++) begin
            red_and &= hist[k];
            red_or  |= hist[k];
        end
        fill_full = (fill_cnt == DEPTH_C);
`ifdef HISTORY_FILL_GATE_EN
        y_next = fill_full ? ((state == S_OR) ? red_or : red_and) : '0;
`else
        y_next = (state == S_OR) ? red_or : red_and;
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            hist     <= '0;
            y        <= '0;
            valid    <= 1'b0;
            fill_cnt <= '0;
        end else if (en) begin
            hist[0] <= a;
            for (int k = 1; k < DEPTH; k++) begin
                hist[k] <= hist[k-1];
            end
            y     <= y_next;
            valid <= fill_full;
            if (!fill_full) begin
                fill_cnt <= fill_cnt + FCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_history_combiner.sv
// Scoreboard bench: a sample-history reference model queues the expected outputs each edge,
// a negedge monitor pops and compares; a HYST=1 instance checks the one-cycle mode follow.
module tb_history_combiner;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int HYST  = 2;

    logic             CLK;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] a;
    logic             b;
    logic [WIDTH-1:0] y,  y1;
    logic             valid, valid1;
    logic             mode, mode1;
    logic             s0, s1, s0_1, s1_1;

    int errors = 0;
    int checks = 0;

    history_combiner #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HYST(HYST)) dut (
        .CLK(CLK), .reset(reset), .en(en), .a(a), .b(b),
        .y(y), .valid(valid), .mode(mode), .i_am_in_S0(s0), .i_am_in_S1(s1)
    );

    history_combiner #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HYST(1)) dut1 (
        .CLK(CLK), .reset(reset), .en(en), .a(a), .b(b),
        .y(y1), .valid(valid1), .mode(mode1), .i_am_in_S0(s0_1), .i_am_in_S1(s1_1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             v;
        logic             m;
        logic [WIDTH-1:0] y1;
        logic             m1;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Reference model: keeps the last DEPTH enabled samples as plain values (missing = 0).
    logic [WIDTH-1:0] m_hist [DEPTH];
    int               m_n;
    logic [WIDTH-1:0] m_y, m_y1, all_and, any_or;
    logic             m_v, m_mode, m_mode1, m_ok;
    int               m_dis;

    always @(posedge CLK) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) m_hist[k] = '0;
            m_n = 0; m_y = '0; m_y1 = '0; m_v = 1'b0;
            m_mode = 1'b0; m_mode1 = 1'b0; m_dis = 0;
        end else begin
            if (en) begin
                all_and = a;
                any_or  = a;
                for (int k = 0; k < DEPTH; k++) begin
                    all_and = all_and & m_hist[k];
                    any_or  = any_or | m_hist[k];
                end
                m_ok = (m_n >= DEPTH);
                m_y  = m_mode  ? any_or : all_and;
                m_y1 = m_mode1 ? any_or : all_and;
`ifdef HISTORY_FILL_GATE_EN
                if (!m_ok) begin
                    m_y  = '0;
                    m_y1 = '0;
                end
`endif
                if (m_ok) m_v = 1'b1;
                for (int k = DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = a;
                m_n++;
            end
            if (b == m_mode) begin
                m_dis = 0;
            end else begin
                m_dis++;
                if (m_dis == HYST) begin
                    m_mode = !m_mode;
                    m_dis  = 0;
                end
            end
            m_mode1 = b;
        end
        exp_q.push_back('{y: m_y, v: m_v, m: m_mode, y1: m_y1, m1: m_mode1});
    end

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_y",      8'(y),      8'(e.y));
            chk("sb_valid",  8'(valid),  8'(e.v));
            chk("sb_mode",   8'(mode),   8'(e.m));
            chk("sb_s0",     8'(s0),     8'(!e.m));
            chk("sb_s1",     8'(s1),     8'(e.m));
            chk("sb_y_h1",   8'(y1),     8'(e.y1));
            chk("sb_valid1", 8'(valid1), 8'(e.v));
            chk("sb_mode_h1", 8'(mode1), 8'(e.m1));
            chk("sb_s1_h1",  8'(s1_1),   8'(e.m1));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [WIDTH-1:0] aa, input logic bb);
        reset = r; en = e; a = aa; b = bb;
        @(posedge CLK);
        #1;
    endtask

    task automatic dchk(input string name, input logic [WIDTH-1:0] ey, input logic ev, input logic em);
        chk({name, "_y"},     8'(y),     8'(ey));
        chk({name, "_valid"}, 8'(valid), 8'(ev));
        chk({name, "_mode"},  8'(mode),  8'(em));
    endtask

    logic [WIDTH-1:0] or_fill [4];
    logic [WIDTH-1:0] or_gate [3];
    logic             rb;

    initial begin
        reset = 1'b1; en = 1'b0; a = '0; b = 1'b0;
`ifdef HISTORY_FILL_GATE_EN
        or_fill = '{4'h0, 4'h0, 4'h1, 4'h0};
        or_gate = '{4'h0, 4'h0, 4'hF};
`else
        or_fill = '{4'h1, 4'h1, 4'h1, 4'h0};
        or_gate = '{4'hF, 4'hF, 4'hF};
`endif
        cyc(1, 0, 4'h0, 0);
        dchk("reset", 4'h0, 0, 0);

        cyc(0, 1, 4'hF, 0); dchk("and_fill1", 4'h0, 0, 0);
        cyc(0, 1, 4'hF, 0); dchk("and_fill2", 4'h0, 0, 0);
        cyc(0, 1, 4'hF, 0); dchk("and_fill3", 4'hF, 1, 0);

        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, (i % 2) ? 4'hA : 4'h5, 0);
            dchk("en_gap", 4'hF, 1, 0);
        end
        cyc(0, 1, 4'h3, 0); dchk("post_gap", 4'h3, 1, 0);

        cyc(0, 1, 4'hF, 0); cyc(0, 1, 4'hF, 0); cyc(0, 1, 4'hF, 0);
        dchk("pre_reset", 4'hF, 1, 0);
        cyc(1, 0, 4'hF, 1); dchk("mid_reset", 4'h0, 0, 0);
        cyc(0, 1, 4'hF, 0); dchk("refill1", 4'h0, 0, 0);
        cyc(0, 1, 4'hF, 0); dchk("refill2", 4'h0, 0, 0);
        cyc(0, 1, 4'hF, 0); dchk("refill3", 4'hF, 1, 0);

        cyc(0, 0, 4'h0, 1); dchk("glitch_hi", 4'hF, 1, 0);
        cyc(0, 0, 4'h0, 0); dchk("glitch_lo", 4'hF, 1, 0);
        cyc(0, 0, 4'h0, 1); dchk("hyst_1st", 4'hF, 1, 0);
        cyc(0, 0, 4'h0, 1); dchk("hyst_2nd", 4'hF, 1, 1);

        cyc(1, 0, 4'h0, 0);
        cyc(0, 0, 4'h0, 1); dchk("or_sw1", 4'h0, 0, 0);
        cyc(0, 0, 4'h0, 1); dchk("or_sw2", 4'h0, 0, 1);
        cyc(0, 1, 4'h1, 1); dchk("or_fill1", or_fill[0], 0, 1);
        cyc(0, 1, 4'h0, 1); dchk("or_fill2", or_fill[1], 0, 1);
        cyc(0, 1, 4'h0, 1); dchk("or_fill3", or_fill[2], 1, 1);
        cyc(0, 1, 4'h0, 1); dchk("or_fill4", or_fill[3], 1, 1);

        cyc(1, 0, 4'h0, 1);
        cyc(0, 0, 4'h0, 1);
        cyc(0, 0, 4'h0, 1);
        cyc(0, 1, 4'hF, 1); dchk("or_gate1", or_gate[0], 0, 1);
        cyc(0, 1, 4'hF, 1); dchk("or_gate2", or_gate[1], 0, 1);
        cyc(0, 1, 4'hF, 1); dchk("or_gate3", or_gate[2], 1, 1);

        rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) rb = ~rb;
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                WIDTH'($urandom), rb);
        end

        cyc(0, 0, 4'h0, rb);
        @(negedge CLK);
        #1;
        chk("sb_drain", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/history_combiner.md
Name: history_combiner

Overview:
- Parametrised successor to the two-state AND/OR sample combiner.
- Each of WIDTH lanes keeps a DEPTH-deep history of its input and produces a registered output: the current sample reduced with its history by AND or OR.
- A two-state mode FSM with hysteresis selects the reduction.
- Used as a glitch-filter / persistence detector on multi-bit status inputs.

Parameters:
- WIDTH, 4, number of independent lanes (>=1).
- DEPTH, 2, history samples per lane (>=1).
- HYST, 1, consecutive cycles b must disagree with the current mode before the mode switches (>=1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- en  input  1  sample enable; history, y and fill tracking advance only when high.
- a  input  WIDTH  lane input samples.
- b  input  1  mode request: 0 = AND, 1 = OR.
- y  output  WIDTH  registered combined result.
- valid  output  1  y was computed from a fully populated history.
- mode  output  1  current FSM state: 0 = S_AND, 1 = S_OR.
- i_am_in_S0  output  1  mode == S_AND (combinational decode).
- i_am_in_S1  output  1  mode == S_OR (combinational decode).

Behaviour:
- Reset: reset has priority over all other inputs. On a rising edge with reset=1, all of the following clear: FSM = S_AND, hist = 0, y = 0, valid = 0, fill_cnt = 0, hyst_cnt = 0.
- Applies identically when reset is asserted mid-operation; no partial state survives.
- History: per lane, hist[0..DEPTH-1]; hist[0] is the newest sample.
  - On an edge with en=1: hist[0] <= a, hist[k] <= hist[k-1].
  - On an edge with en=0: hist holds.
- Output (edge with en=1): y[i] is computed from a[i] and the pre-shift hist[0..DEPTH-1][i].
  - S_AND: y[i] <= a[i] & all pre-shift hist[*][i].
  - S_OR: y[i] <= a[i] | any pre-shift hist[*][i].
  - The reduction uses the FSM state before this edge's transition.
- Latency: one cycle from the sampling edge to y.
- Output (edge with en=0): y holds.
- Fill tracking: fill_cnt saturates at DEPTH.
  - On an en=1 edge: valid <= (fill_cnt == DEPTH), then fill_cnt <= min(fill_cnt+1, DEPTH).
  - valid first rises on the (DEPTH+1)-th enabled sample after reset; it holds when en=0.
  - valid never falls except on reset.
- Mode FSM: two states, S_AND and S_OR. It advances every cycle, independent of en.
  - If b == mode: hyst_cnt <= 0.
  - Else if hyst_cnt+1 == HYST: toggle state, hyst_cnt <= 0.
  - Else: hyst_cnt <= hyst_cnt+1.
  - hyst_cnt is clog2(HYST+1) bits wide and never wraps.
  - With HYST=1, the state follows b with one cycle of delay.
- Simultaneous events:
  - A mode switch and en on the same edge: y uses the old mode; the next sample uses the new mode.
  - A b glitch shorter than HYST cycles leaves mode unchanged and clears hyst_cnt.
- Illegal state encoding recovers to S_AND on the next edge.

Optional Feature:
- Macro: HISTORY_FILL_GATE_EN.
- Defined: y is forced to 0 on any en=1 edge whose computed valid is 0, so partial history never reaches y. In OR mode this suppresses early ones.
- Undefined: y is computed from zero-initialised history during fill. Early S_OR results may be 1; early S_AND results are 0.
- valid behaves identically in both builds.

Test Plan:
Test parameters: WIDTH=4, DEPTH=2, HYST=2; macro undefined unless stated.
- Fill, S_AND: reset, then 3 en pulses with a=4'hF, b=0 -> y=0,0,4'hF; valid=0,0,1.
- Fill, S_OR: after reset, hold b=1 for 2 cycles -> mode=1 after the 2nd edge. Then en with a=4'h1, 4'h0, 4'h0 -> y=4'h1, 4'h1, 4'h1; the 4th sample a=0 -> y=0.
- Hysteresis: in S_AND, b=1 for 1 cycle then b=0 -> mode stays 0 and hyst_cnt returns to 0. With HYST=1, a 1-cycle b=1 -> mode=1 on the next edge.
- Enable gating: with valid=1, hold en=0 for 5 cycles while a toggles 4'h5/4'hA -> y, valid and hist unchanged. The next en uses the pre-gap history.
- Mid-operation reset: with valid=1 and y=4'hF, assert reset for 1 cycle -> y=0, valid=0, mode=0. valid rises again only on the 3rd subsequent en.
- HISTORY_FILL_GATE_EN defined: in S_OR, first two en pulses with a=4'hF -> y=0,0; 3rd pulse -> y=4'hF, valid=1.
